// File: rtl/alarm_bank.sv
// Multi-slot BCD alarm store with load validation, per-minute match
// and a ring / snooze / off sounder state machine.
module alarm_bank #(
  parameter int NUM_ALARMS = 4,
  parameter int SLOT_W     = 2,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MIN   = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_new_alarm,
  input  logic [SLOT_W-1:0]     load_slot,
  input  logic                  load_enable,
  input  logic [3:0]            new_alarm_ms_hr,
  input  logic [3:0]            new_alarm_ls_hr,
  input  logic [3:0]            new_alarm_ms_min,
  input  logic [3:0]            new_alarm_ls_min,
  input  logic [SLOT_W-1:0]     rd_slot,
  input  logic [3:0]            cur_ms_hr,
  input  logic [3:0]            cur_ls_hr,
  input  logic [3:0]            cur_ms_min,
  input  logic [3:0]            cur_ls_min,
  input  logic                  minute_tick,
  input  logic                  snooze_req,
  input  logic                  alarm_off,
  output logic [3:0]            alarm_time_ms_hr,
  output logic [3:0]            alarm_time_ls_hr,
  output logic [3:0]            alarm_time_ms_min,
  output logic [3:0]            alarm_time_ls_min,
  output logic [NUM_ALARMS-1:0] alarm_en_mask,
  output logic                  load_error,
  output logic                  sound_alarm,
  output logic                  snoozing,
  output logic [SLOT_W-1:0]     active_slot
);

  typedef enum logic [1:0] {
    IDLE,
    RINGING,
    SNOOZE
  } state_t;

  state_t      state;
  logic [3:0]  ring_cnt;
  logic [3:0]  snz_cnt;

  logic [15:0] slot_time [NUM_ALARMS];
  logic [15:0] new_time;
  logic [15:0] cur_time;
  logic [15:0] rd_time;

  logic              slot_ok;
  logic              time_ok;
  logic              ld_ok;
  logic              cancel;
  logic              hit;
  logic [SLOT_W-1:0] hit_slot;

  assign new_time = {new_alarm_ms_hr, new_alarm_ls_hr,
                     new_alarm_ms_min, new_alarm_ls_min};
  assign cur_time = {cur_ms_hr, cur_ls_hr,
                     cur_ms_min, cur_ls_min};

  // Tens-of-hours limit also bounds the units digit only when it is 2.
  assign time_ok = (new_alarm_ms_hr <= 4'd2)
                && (new_alarm_ls_hr <= 4'd9)
                && (new_alarm_ms_min <= 4'd5)
                && (new_alarm_ls_min <= 4'd9)
                && !((new_alarm_ms_hr == 4'd2)
                     && (new_alarm_ls_hr > 4'd3));

  assign slot_ok = 32'(load_slot) < NUM_ALARMS;
  assign ld_ok   = slot_ok && time_ok;
  assign cancel  = load_new_alarm && ld_ok
                && (load_slot == active_slot);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        slot_time[i] <= '0;
      end
      alarm_en_mask <= '0;
      load_error    <= 1'b0;
    end else begin
      load_error <= load_new_alarm && !ld_ok;
      if (load_new_alarm && ld_ok) begin
        slot_time[load_slot]     <= new_time;
        alarm_en_mask[load_slot] <= load_enable;
      end
    end
  end

  assign rd_time = (32'(rd_slot) < NUM_ALARMS)
                 ? slot_time[rd_slot] : '0;

  assign alarm_time_ms_hr  = rd_time[15:12];
  assign alarm_time_ls_hr  = rd_time[11:8];
  assign alarm_time_ms_min = rd_time[7:4];
  assign alarm_time_ls_min = rd_time[3:0];

  // Downward scan so the lowest matching slot is the last one written.
  always_comb begin
    hit      = 1'b0;
    hit_slot = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (alarm_en_mask[i] && (slot_time[i] == cur_time)) begin
        hit      = 1'b1;
        hit_slot = SLOT_W'(i);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ring_cnt    <= '0;
      snz_cnt     <= '0;
      sound_alarm <= 1'b0;
      snoozing    <= 1'b0;
      active_slot <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!alarm_off && minute_tick && hit) begin
            state       <= RINGING;
            sound_alarm <= 1'b1;
            active_slot <= hit_slot;
            ring_cnt    <= '0;
          end
        end
        RINGING: begin
          if (alarm_off || cancel) begin
            state       <= IDLE;
            sound_alarm <= 1'b0;
            snoozing    <= 1'b0;
            active_slot <= '0;
            ring_cnt    <= '0;
            snz_cnt     <= '0;
          end else if (snooze_req) begin
            state       <= SNOOZE;
            sound_alarm <= 1'b0;
            snoozing    <= 1'b1;
            snz_cnt     <= 4'(SNOOZE_MIN);
          end else if (minute_tick) begin
            if (ring_cnt >= 4'(RING_MIN - 1)) begin
              state       <= IDLE;
              sound_alarm <= 1'b0;
              active_slot <= '0;
              ring_cnt    <= '0;
            end else if (ring_cnt != 4'hF) begin
              ring_cnt <= ring_cnt + 4'd1;
            end
          end
        end
        SNOOZE: begin
          if (alarm_off || cancel) begin
            state       <= IDLE;
            sound_alarm <= 1'b0;
            snoozing    <= 1'b0;
            active_slot <= '0;
            ring_cnt    <= '0;
            snz_cnt     <= '0;
          end else if (minute_tick) begin
            if (snz_cnt <= 4'd1) begin
              state       <= RINGING;
              sound_alarm <= 1'b1;
              snoozing    <= 1'b0;
              snz_cnt     <= '0;
              ring_cnt    <= '0;
            end else begin
              snz_cnt <= snz_cnt - 4'd1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          sound_alarm <= 1'b0;
          snoozing    <= 1'b0;
          active_slot <= '0;
          ring_cnt    <= '0;
          snz_cnt     <= '0;
        end
      endcase
    end
  end

endmodule
